// File: rtl/inmem_arb_pkg.sv
// Shared definitions for the in-memory burst arbiter: FSM encoding and default sizing.
package inmem_pkg;
    localparam int DEF_NREQ    = 4;
    localparam int DEF_AW      = 10;
    localparam int DEF_DW      = 16;
    localparam int DEF_DELTA_T = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_t;
endpackage

// File: rtl/inmem_arb_if.sv
// Request/grant, shared memory read port and output stream of inmem_arb, plus FSM debug state.
interface inmem_arb_if import inmem_pkg::*; #(
    parameter int NREQ = DEF_NREQ,
    parameter int AW   = DEF_AW,
    parameter int DW   = DEF_DW
) ();
    localparam int CW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // req is a level held by the requester until its fo pulse; rdata is valid one cycle after re.
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] base_i;
    logic [NREQ*AW-1:0] len_i;
    logic [NREQ-1:0]    gnt;
    logic               re;
    logic [AW-1:0]      adr;
    logic [DW-1:0]      rdata;
    logic [DW-1:0]      do_o;
    logic               vo;
    logic [CW-1:0]      ch;
    logic [NREQ-1:0]    fo;
    logic               busy;
    state_t             dbg_state;

    modport master (
        output req, base_i, len_i, rdata,
        input  gnt, re, adr, do_o, vo, ch, fo, busy, dbg_state
    );

    modport slave (
        input  req, base_i, len_i, rdata,
        output gnt, re, adr, do_o, vo, ch, fo, busy, dbg_state
    );
endinterface

// File: rtl/inmem_arb_rr_pick.sv
// Round-robin picker: first asserted request at or after the pointer, wrapping, as a one-hot grant.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int CW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [CW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o
);
    int   j;
    logic found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr_i) + k) % NREQ;
            if (!found && req_i[j]) begin
                gnt_o[j] = 1'b1;
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/inmem_arb.sv
// Arbitrates NREQ channels onto one memory read port; each grant waits DELTA_T cycles, then streams len words.
module inmem_arb import inmem_pkg::*; #(
    parameter int NREQ    = DEF_NREQ,
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int DELTA_T = DEF_DELTA_T
) (
    input logic        clk,
    input logic        reset,
    inmem_arb_if.slave bus
);
    localparam int            CW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [AW-1:0] DLY_LAST = (DELTA_T > 0) ? AW'(DELTA_T - 1) : '0;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d, pick;
    logic [CW-1:0]   idx_q, idx_d, ptr_q, ptr_d, pick_idx;
    logic [AW-1:0]   base_q, base_d, len_q, len_d, cnt_q, cnt_d, adr_q, adr_d, adr_cur;
    logic            vo_q, re_c;

    rr_pick #(.NREQ(NREQ), .CW(CW)) u_pick (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .gnt_o (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick[i]) pick_idx = CW'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        base_d  = base_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        re_c    = 1'b0;
        adr_cur = adr_q;
        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    gnt_d  = pick;
                    idx_d  = pick_idx;
                    base_d = bus.base_i[int'(pick_idx)*AW +: AW];
                    len_d  = bus.len_i[int'(pick_idx)*AW +: AW];
                    cnt_d  = '0;
                    if (DELTA_T != 0)   state_d = ST_DELAY;
                    else if (len_d == '0) state_d = ST_DONE;
                    else                state_d = ST_STREAM;
                end
            end
            ST_DELAY: begin
                if (cnt_q == DLY_LAST) begin
                    cnt_d   = '0;
                    state_d = (len_q == '0) ? ST_DONE : ST_STREAM;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            ST_STREAM: begin
                // Address arithmetic is AW bits wide, so bursts wrap around the top of memory.
                re_c    = 1'b1;
                adr_cur = base_q + cnt_q;
                adr_d   = adr_cur;
                if (cnt_q == len_q - AW'(1)) state_d = ST_DONE;
                else                         cnt_d   = cnt_q + AW'(1);
            end
            ST_DONE: begin
                gnt_d   = '0;
                ptr_d   = (idx_q == CW'(NREQ - 1)) ? '0 : idx_q + CW'(1);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            base_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            adr_q   <= '0;
            vo_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            base_q  <= base_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            vo_q    <= re_c;
        end
    end

    // The final vo of a burst always lands in DONE, which is also where an empty burst finishes.
    assign bus.gnt       = gnt_q;
    assign bus.re        = re_c;
    assign bus.adr       = adr_cur;
    assign bus.vo        = vo_q;
    assign bus.do_o      = vo_q ? bus.rdata : '0;
    assign bus.ch        = idx_q;
    assign bus.fo        = (state_q == ST_DONE) ? gnt_q : '0;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.dbg_state = state_q;
endmodule
